// File: rtl/fire8_pkg.sv
// ============================================================================
// Module   : fire8_pkg
// Brief    : Shared constants and types for the fire8 squeeze datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fire8_pkg;

    localparam int FIRE8_WOUT       = 8;
    localparam int FIRE8_DSP_NO     = 112;
    localparam int FIRE8_WIDTH      = 16;
    localparam int FIRE8_OFM_ADDR_W = $clog2(FIRE8_WOUT * FIRE8_WOUT * FIRE8_DSP_NO);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } ofm_wr_state_t;

endpackage

`default_nettype wire

// File: rtl/fire8_squeeze_ofm_writer.sv
// ============================================================================
// Module   : fire8_squeeze_ofm_writer
// Brief    : Captures each squeeze output pixel and serialises it into the
//            fire8 feature-map RAM, pixel-major / channel-fastest.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fire8_squeeze_ofm_writer
    import fire8_pkg::*;
#(
    parameter int WOUT   = FIRE8_WOUT,
    parameter int DSP_NO = FIRE8_DSP_NO,
    parameter int WIDTH  = FIRE8_WIDTH,
    parameter int ADDR_W = $clog2(WOUT**2 * DSP_NO)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              layer_en,
    input  logic              sample,
    input  logic [WIDTH-1:0]  ofm [DSP_NO],
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WIDTH-1:0]  ram_wdata,
    output logic              ram_feedback,
    output logic              done,
    output logic              overrun
);

    localparam int PIX_NO = WOUT * WOUT;
    localparam int PIX_W  = $clog2(PIX_NO);
    localparam int CH_W   = $clog2(DSP_NO);

    ofm_wr_state_t     r_state;
    logic [PIX_W-1:0]  r_pix_cnt;
    logic [CH_W-1:0]   r_ch_cnt;
    logic [WIDTH-1:0]  r_shadow [DSP_NO];

    logic              w_capture;
    logic              w_last_ch;
    logic              w_last_pix;
    logic [ADDR_W-1:0] w_addr;

    // A sample only lands when armed and still enabled; this must match the FSM.
    assign w_capture  = (r_state == ARMED) && layer_en && sample;
    assign w_last_ch  = (r_ch_cnt == CH_W'(DSP_NO - 1));
    assign w_last_pix = (r_pix_cnt == PIX_W'(PIX_NO - 1));
    assign w_addr     = ADDR_W'(r_pix_cnt) * ADDR_W'(DSP_NO) + ADDR_W'(r_ch_cnt);

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_shadow <= ofm;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pix_cnt    <= '0;
            r_ch_cnt     <= '0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            ram_feedback <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            ram_we       <= 1'b0;
            ram_feedback <= 1'b0;

            if (sample && (r_state == WRITE)) begin
                overrun <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_pix_cnt <= '0;
                    r_ch_cnt  <= '0;
                    done      <= 1'b0;
                    if (layer_en) begin
                        r_state <= ARMED;
                    end
                end

                ARMED: begin
                    if (!layer_en) begin
                        r_state <= IDLE;
                    end else if (w_capture) begin
                        r_state  <= WRITE;
                        r_ch_cnt <= '0;
                    end
                end

                WRITE: begin
                    ram_we    <= 1'b1;
                    ram_addr  <= w_addr;
                    ram_wdata <= r_shadow[r_ch_cnt];
                    if (w_last_ch) begin
                        r_ch_cnt  <= '0;
                        r_pix_cnt <= r_pix_cnt + PIX_W'(1);
                        // A disabled layer finishes its burst but never reports completion.
                        if (!layer_en) begin
                            r_state <= IDLE;
                        end else if (w_last_pix) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= ARMED;
                        end
                    end else begin
                        r_ch_cnt <= r_ch_cnt + CH_W'(1);
                    end
                end

                DONE: begin
                    if (!layer_en) begin
                        r_state <= IDLE;
                        done    <= 1'b0;
                    end else begin
                        done         <= 1'b1;
                        ram_feedback <= ~done;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/fire8_squeeze_ofm_writer.md
# fire8_squeeze_ofm_writer

Downstream stage of the fire8 squeeze convolution. Captures the 112-channel output vector each time the squeeze core flags an output pixel and serialises it into the single-port fire8 feature-map RAM. Addressing is pixel-major, channel-fastest. After the last of the 64 pixels is written, it returns the `ram_feedback` pulse to the squeeze core and holds `done` for the layer controller.

## Interface
Parameters:
- `WOUT`, 8: output feature-map side; `WOUT**2` pixels per layer.
- `DSP_NO`, 112: channels per pixel, equal to the squeeze MAC count.
- `WIDTH`, 16: bits per channel value.
- `ADDR_W`, `$clog2(WOUT**2*DSP_NO)` (13): RAM address width.

Ports:
- `clk`, in, 1: single clock. All logic is on its rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `layer_en`, in, 1: layer enable from the controller. Writer is armed while high.
- `sample`, in, 1: one-cycle pulse from the squeeze core; `ofm` is valid in the same cycle.
- `ofm`, in, `WIDTH` x `DSP_NO` (unpacked array): ReLU'd, Q-format channel values.
- `ram_we`, out, 1: RAM write enable.
- `ram_addr`, out, `ADDR_W`: RAM write address.
- `ram_wdata`, out, `WIDTH`: RAM write data.
- `ram_feedback`, out, 1: one-cycle pulse after the final RAM write.
- `done`, out, 1: level, high from the final write until `layer_en` falls.
- `overrun`, out, 1: sticky error; a `sample` arrived while the writer was busy.

## Operation
- State machine: `IDLE`, `ARMED`, `WRITE`, `DONE`.
- `IDLE` -> `ARMED` when `layer_en`=1.
- `ARMED` -> `WRITE` on `sample`:
  - All `DSP_NO` words are copied into a shadow bank.
  - `ch_cnt` is cleared.
- `WRITE`: one word per cycle.
  - `ram_we`=1, `ram_addr`=`pix_cnt*DSP_NO + ch_cnt`, `ram_wdata`=`shadow[ch_cnt]`.
  - At `ch_cnt`=`DSP_NO-1`, `pix_cnt` increments.
  - Next state is `DONE` if `pix_cnt`=`WOUT**2-1`; otherwise `ARMED`.
- `DONE`: `done`=1. Returns to `IDLE` when `layer_en`=0; counters are cleared there.
- `sample` in `WRITE`:
  - The sample is discarded and the shadow bank is left unchanged.
  - `overrun` is set and stays set until reset.
- `sample` in `IDLE` or `DONE` is ignored with no flag.
- `layer_en` falling in `ARMED` or `WRITE`:
  - The current pixel burst completes.
  - The FSM then goes to `IDLE`, with no `ram_feedback`.
- Address arithmetic is unsigned with no wrap. The maximum is `WOUT**2*DSP_NO-1` = 7167.
- Data passes through bit-exact; no saturation or rescale.

## Timing
- Reset (`rst_n`=0 at a clock edge) forces, at that edge:
  - state `IDLE`;
  - `pix_cnt`=0, `ch_cnt`=0;
  - `ram_we`=0, `ram_addr`=0, `ram_wdata`=0;
  - `ram_feedback`=0, `done`=0, `overrun`=0.
- Reset mid-burst abandons the burst; a partial pixel stays in RAM.
- Write timing for a `sample` at edge t:
  - Capture happens at t.
  - First write `ch0` is registered on the outputs at t+1.
  - Last write `ch111` is at t+112.
  - Back in `ARMED` at t+113, when a new `sample` is accepted.
- Squeeze pixel period is `9*384+1` = 3457 cycles, far above 113, so `overrun` never fires in normal operation.
- For the final pixel:
  - `ram_feedback`=1 and `done`=1 at t+113.
  - `ram_feedback` drops at t+114; `done` holds.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `fire8_pkg`:
  - constants `FIRE8_WOUT`, `FIRE8_DSP_NO`, `FIRE8_WIDTH`, `FIRE8_OFM_ADDR_W`;
  - `typedef enum logic [1:0] {IDLE, ARMED, WRITE, DONE} ofm_wr_state_t`.
- Single module; no sub-module. Shadow bank, counters and FSM live inline, about 150 lines of RTL.

## Test plan
- Reset check:
  - Stimulus: hold `rst_n`=0 for 3 cycles with `layer_en`=1 and `sample` pulsing.
  - Required: all outputs 0, no `ram_we`.
- Single pixel:
  - Stimulus: `layer_en`=1; one `sample` with `ofm[i]`=16'h0100+i.
  - Required: 112 consecutive writes, addr 0..111, data 16'h0100..16'h016F; `ram_we` low afterwards.
- Full layer:
  - Stimulus: 64 `sample` pulses every 3457 cycles, with `ofm[i]`=`{pix[7:0],i[7:0]}`.
  - Required: 7168 writes; addr 7167 carries data 16'h3F6F; `ram_feedback` is a single pulse 1 cycle after it; `done` stays high.
- Overrun:
  - Stimulus: second `sample` 50 cycles after the first.
  - Required: `overrun`=1; the writes for the first pixel are unaffected; the second pixel is not written; the next valid sample writes addr 112..223.
- Reset mid-burst:
  - Stimulus: `rst_n`=0 during write 40 of pixel 5.
  - Required: `ram_we`=0 next cycle; counters are 0; a re-armed layer starts again at addr 0.
- Disable and re-arm:
  - Stimulus: drop `layer_en` in `DONE`, then raise it again.
  - Required: `done` falls; the next `sample` writes from addr 0.
